// File: rtl/morse_decoder_module_pkg.sv
// Shared constants for the Morse decoder: ASCII codes, timing multipliers
// (in Morse units) and the decoder FSM state encoding.
package morse_decoder_module_pkg;

  localparam int unsigned DUR_W = 12;
  localparam int unsigned PAT_W = 5;
  localparam int unsigned CNT_W = 3;

  localparam int unsigned DOT_MUL      = 2;
  localparam int unsigned DASH_MUL     = 6;
  localparam int unsigned CHAR_GAP_MUL = 2;
  localparam int unsigned WORD_GAP_MUL = 5;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
  localparam logic [7:0] ASCII_S       = 8'h53;
  localparam logic [7:0] ASCII_O       = 8'h4F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_WORD
  } state_t;

endpackage

// File: rtl/key_debounce_module.sv
// Key synchronizer and tick-based debouncer; the level only follows the
// synchronized key after DEB_MS consecutive ticks of disagreement.
module key_debounce_module #(
  parameter int unsigned DEB_MS = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic key_raw,
  output logic key_level
);
  localparam int unsigned DW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

  logic          sync0;
  logic          sync1;
  logic [DW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync0     <= 1'b1;
      sync1     <= 1'b1;
      cnt       <= '0;
      key_level <= 1'b1;
    end else begin
      sync0 <= key_raw;
      sync1 <= sync0;
      // any return to the current level restarts the stability window
      if (sync1 == key_level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == DW'(DEB_MS - 1)) begin
          cnt       <= '0;
          key_level <= sync1;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/morse_decoder_module.sv
// Morse key decoder: times debounced marks/spaces in ms ticks, builds a
// dot/dash pattern, emits ASCII strobes, word spaces and S,O,S detection.
module morse_decoder_module
  import morse_decoder_module_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB_MS   = 10,
  parameter int unsigned UNIT_MS  = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Key_In,
  output logic       Char_Valid,
  output logic [7:0] Char_Data,
  output logic       Err_Sig,
  output logic       SOS_Det_Sig
);
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DUR_W-1:0] DOT_MAX   = DUR_W'(DOT_MUL * UNIT_MS);
  localparam logic [DUR_W-1:0] DASH_MAX  = DUR_W'(DASH_MUL * UNIT_MS);
  localparam logic [DUR_W-1:0] CHAR_LAST = DUR_W'(CHAR_GAP_MUL * UNIT_MS - 1);
  localparam logic [DUR_W-1:0] WORD_LAST = DUR_W'(WORD_GAP_MUL * UNIT_MS - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             key_level;
  logic             key_prev;
  logic             press_edge;
  logic             release_edge;
  logic [DUR_W-1:0] dur;
  logic             char_gap;
  logic             word_gap;

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] pat_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_flag;
  logic             err_nxt;
  logic             emit;
  logic [7:0]       emit_char;
  logic [7:0]       hist0;
  logic [7:0]       hist1;
  logic             sos_hit;

  // Pattern bit i is element i (0 = dot, 1 = dash); count selects the length.
  function automatic logic [7:0] decode(input logic [CNT_W-1:0] n,
                                        input logic [PAT_W-1:0] p);
    decode = ASCII_UNKNOWN;
    case ({n, p})
      {3'd2, 5'd2}:  decode = 8'h41; {3'd4, 5'd1}:  decode = 8'h42;
      {3'd4, 5'd5}:  decode = 8'h43; {3'd3, 5'd1}:  decode = 8'h44;
      {3'd1, 5'd0}:  decode = 8'h45; {3'd4, 5'd4}:  decode = 8'h46;
      {3'd3, 5'd3}:  decode = 8'h47; {3'd4, 5'd0}:  decode = 8'h48;
      {3'd2, 5'd0}:  decode = 8'h49; {3'd4, 5'd14}: decode = 8'h4A;
      {3'd3, 5'd5}:  decode = 8'h4B; {3'd4, 5'd2}:  decode = 8'h4C;
      {3'd2, 5'd3}:  decode = 8'h4D; {3'd2, 5'd1}:  decode = 8'h4E;
      {3'd3, 5'd7}:  decode = 8'h4F; {3'd4, 5'd6}:  decode = 8'h50;
      {3'd4, 5'd11}: decode = 8'h51; {3'd3, 5'd2}:  decode = 8'h52;
      {3'd3, 5'd0}:  decode = 8'h53; {3'd1, 5'd1}:  decode = 8'h54;
      {3'd3, 5'd4}:  decode = 8'h55; {3'd4, 5'd8}:  decode = 8'h56;
      {3'd3, 5'd6}:  decode = 8'h57; {3'd4, 5'd9}:  decode = 8'h58;
      {3'd4, 5'd13}: decode = 8'h59; {3'd4, 5'd3}:  decode = 8'h5A;
      {3'd5, 5'd31}: decode = 8'h30; {3'd5, 5'd30}: decode = 8'h31;
      {3'd5, 5'd28}: decode = 8'h32; {3'd5, 5'd24}: decode = 8'h33;
      {3'd5, 5'd16}: decode = 8'h34; {3'd5, 5'd0}:  decode = 8'h35;
      {3'd5, 5'd1}:  decode = 8'h36; {3'd5, 5'd3}:  decode = 8'h37;
      {3'd5, 5'd7}:  decode = 8'h38; {3'd5, 5'd15}: decode = 8'h39;
      default:       decode = ASCII_UNKNOWN;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  key_debounce_module #(.DEB_MS(DEB_MS)) u_debounce (
    .CLK       (CLK),
    .RST       (RST),
    .tick      (tick),
    .key_raw   (Key_In),
    .key_level (key_level)
  );

  assign press_edge   = key_prev & ~key_level;
  assign release_edge = ~key_prev & key_level;
  assign char_gap     = tick && (dur == CHAR_LAST);
  assign word_gap     = tick && (dur == WORD_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_prev <= 1'b1;
      dur      <= '0;
    end else begin
      key_prev <= key_level;
      if (press_edge || release_edge) begin
        dur <= '0;
      end else if (tick && dur != DUR_MAX) begin
        dur <= dur + DUR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    cnt_nxt   = cnt;
    err_nxt   = err_flag;
    emit      = 1'b0;
    emit_char = ASCII_UNKNOWN;
    case (state)
      ST_IDLE: if (press_edge) state_nxt = ST_MARK;
      ST_MARK: begin
        if (release_edge) begin
          state_nxt = ST_SPACE;
          if (dur > DASH_MAX || cnt == CNT_W'(PAT_W)) begin
            err_nxt = 1'b1;
          end else begin
            pat_nxt[cnt] = (dur > DOT_MAX);
            cnt_nxt      = cnt + CNT_W'(1);
          end
        end
      end
      ST_SPACE: begin
        // a press coinciding with the gap still gets the character out first
        if (char_gap) begin
          emit      = 1'b1;
          emit_char = err_flag ? ASCII_UNKNOWN : decode(cnt, pat);
          pat_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = press_edge ? ST_MARK : ST_WORD;
        end else if (press_edge) begin
          state_nxt = ST_MARK;
        end
      end
      ST_WORD: begin
        if (press_edge) begin
          state_nxt = ST_MARK;
        end else if (word_gap) begin
          emit      = 1'b1;
          emit_char = ASCII_SPACE;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Incoming char plus the two stored ones form the 3-character window.
  assign sos_hit = (emit_char == ASCII_S) && (hist0 == ASCII_O) && (hist1 == ASCII_S);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat         <= '0;
      cnt         <= '0;
      err_flag    <= 1'b0;
      hist0       <= 8'h00;
      hist1       <= 8'h00;
      Char_Valid  <= 1'b0;
      Char_Data   <= 8'h00;
      Err_Sig     <= 1'b0;
      SOS_Det_Sig <= 1'b0;
    end else begin
      pat         <= pat_nxt;
      cnt         <= cnt_nxt;
      err_flag    <= err_nxt;
      Char_Valid  <= emit;
      Err_Sig     <= emit && (emit_char == ASCII_UNKNOWN);
      SOS_Det_Sig <= emit && sos_hit;
      if (emit) begin
        Char_Data <= emit_char;
        if (emit_char == ASCII_SPACE || emit_char == ASCII_UNKNOWN) begin
          hist0 <= 8'h00;
          hist1 <= 8'h00;
        end else begin
          hist0 <= emit_char;
          hist1 <= hist0;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_decoder_module.sv
// Scoreboard bench for morse_decoder_module: keying tasks push expected
// strobes, a negedge monitor pops and compares them.
module tb_morse_decoder_module;
  localparam int TICK = 10;

  typedef struct packed {
    logic [7:0] ch;
    logic       err;
    logic       sos;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b1;
  logic       char_valid;
  logic [7:0] char_data;
  logic       err_sig;
  logic       sos_sig;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total   = 0;
  int   bad     = 0;
  int   strobes = 0;

  morse_decoder_module #(.TICK_DIV(10), .DEB_MS(2), .UNIT_MS(10)) dut (
    .CLK         (clk),
    .RST         (rst),
    .Key_In      (key),
    .Char_Valid  (char_valid),
    .Char_Data   (char_data),
    .Err_Sig     (err_sig),
    .SOS_Det_Sig (sos_sig)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && char_valid) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got data=%h err=%b sos=%b, required no strobe",
                 char_data, err_sig, sos_sig);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (char_data !== mon_e.ch) begin
          bad++;
          $display("FAIL strobe_data: got %h, required %h", char_data, mon_e.ch);
        end
        total++;
        if (err_sig !== mon_e.err) begin
          bad++;
          $display("FAIL strobe_err (char %h): got %b, required %b", mon_e.ch, err_sig, mon_e.err);
        end
        total++;
        if (sos_sig !== mon_e.sos) begin
          bad++;
          $display("FAIL strobe_sos (char %h): got %b, required %b", mon_e.ch, sos_sig, mon_e.sos);
        end
      end
    end else if (!rst && (err_sig || sos_sig)) begin
      total++; bad++;
      $display("FAIL stray_flag: err=%b sos=%b without Char_Valid, required 0 0", err_sig, sos_sig);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic wait_ms(input int n);
    repeat (n * TICK) @(negedge clk);
  endtask

  task automatic mark(input int ms);
    key = 1'b0;
    wait_ms(ms);
    key = 1'b1;
  endtask

  task automatic expect_char(input logic [7:0] ch, input logic err, input logic sos);
    exp_t e;
    e.ch = ch; e.err = err; e.sos = sos;
    exp_q.push_back(e);
  endtask

  // '.' = 10 ms dot, '-' = 30 ms dash, 'L' = 70 ms over-long mark; 30 ms char gap after.
  task automatic send_char(input string code);
    for (int i = 0; i < code.len(); i++) begin
      if (i > 0) wait_ms(10);
      if (code[i] == "-")      mark(30);
      else if (code[i] == "L") mark(70);
      else                     mark(10);
    end
    wait_ms(30);
  endtask

  task automatic wait_drain(input int max_ms, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < max_ms * TICK) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", char_valid); end
    total++; if (char_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h, required 00", char_data); end
    total++; if (err_sig !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, required 0", err_sig); end
    total++; if (sos_sig !== 1'b0) begin bad++; $display("FAIL rst_sos: got %b, required 0", sos_sig); end
    rst = 1'b0;
    wait_ms(10);
    total++; if (char_data !== 8'h00) begin bad++; $display("FAIL idle_data: got %h, required 00", char_data); end
  endtask

  task automatic test_letter_a;
    bit ok;
    expect_char(8'h41, 1'b0, 1'b0);
    send_char(".-");
    wait_drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL a_drain: pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    wait_ms(5);
    total++; if (char_data !== 8'h41) begin bad++; $display("FAIL a_hold: got %h, required 41", char_data); end
    total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL a_valid_low: got %b, required 0", char_valid); end
  endtask

  task automatic test_sos;
    bit ok;
    expect_char(8'h53, 1'b0, 1'b0); send_char("...");
    expect_char(8'h4F, 1'b0, 1'b0); send_char("---");
    expect_char(8'h53, 1'b0, 1'b1); send_char("...");
    wait_drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL sos_drain: pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_overflow;
    bit ok;
    expect_char(8'h3F, 1'b1, 1'b0); send_char("......");
    expect_char(8'h45, 1'b0, 1'b0); send_char(".");
    wait_drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain: pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_glitch_long;
    bit ok;
    expect_char(8'h49, 1'b0, 1'b0);
    mark(10); wait_ms(4); mark(1); wait_ms(5);
    mark(10); wait_ms(4); mark(1); wait_ms(25);
    expect_char(8'h3F, 1'b1, 1'b0); send_char("L");
    wait_drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL glitch_drain: pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_word_gap;
    bit ok;
    int s0 = strobes;
    expect_char(8'h54, 1'b0, 1'b0); send_char("-");
    expect_char(8'h20, 1'b0, 1'b0); wait_ms(30);
    wait_ms(200);
    wait_drain(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL word_drain: pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    total++; if (strobes - s0 != 2) begin bad++; $display("FAIL word_strobes: got %0d, required 2", strobes - s0); end
    total++; if (char_data !== 8'h20) begin bad++; $display("FAIL word_hold: got %h, required 20", char_data); end
  endtask

  task automatic test_reset_mid_char;
    bit ok;
    mark(10); wait_ms(10); mark(10); wait_ms(5);
    rst = 1'b1;
    @(negedge clk);
    total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b, required 0", char_valid); end
    total++; if (char_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h, required 00", char_data); end
    total++; if (err_sig !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b, required 0", err_sig); end
    total++; if (sos_sig !== 1'b0) begin bad++; $display("FAIL mid_rst_sos: got %b, required 0", sos_sig); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ms(40);
    total++; if (strobes != 0 && char_data !== 8'h00) begin bad++; $display("FAIL mid_rst_quiet: data=%h, required 00", char_data); end
    expect_char(8'h54, 1'b0, 1'b0); send_char("-");
    wait_drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_drain: pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_sos();
    test_overflow();
    test_glitch_long();
    test_word_gap();
    test_reset_mid_char();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
